// File: rtl/iir_sos_seq_if.sv
// Bundles the sample, coefficient and result handshakes plus the IIR-section
// control lines that pass between the sequencer and its surroundings.
//   slave  : sequencer side (iir_sos_seq)
//   master : environment side (sample source, config writer, IIR section)
interface iir_sos_seq_if #(
    parameter int unsigned SAMP_WH  = 3,
    parameter int unsigned SAMP_FR  = 22,
    parameter int unsigned COEFF_WH = 2,
    parameter int unsigned COEFF_FR = 15
);
    localparam int unsigned SAMP_W  = SAMP_WH + SAMP_FR;
    localparam int unsigned COEFF_W = COEFF_WH + COEFF_FR;

    logic               in_valid;
    logic               in_ready;
    logic [SAMP_W-1:0]  in_data;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [1:0]         cfg_addr;
    logic [COEFF_W-1:0] cfg_data;
    logic               sos_ce;
    logic               sos_mult_sel;
    logic               sos_c_we;
    logic [1:0]         sos_c_addr;
    logic [COEFF_W-1:0] sos_c_in;
    logic [SAMP_W-1:0]  sos_din;
    logic [SAMP_W-1:0]  sos_dout;
    logic               out_valid;
    logic [SAMP_W-1:0]  out_data;
    logic [2:0]         loaded;
    logic               cfg_err;

    modport slave (
        input  in_valid, in_data, cfg_valid, cfg_addr, cfg_data, sos_dout,
        output in_ready, cfg_ready, sos_ce, sos_mult_sel, sos_c_we, sos_c_addr,
               sos_c_in, sos_din, out_valid, out_data, loaded, cfg_err
    );

    modport master (
        output in_valid, in_data, cfg_valid, cfg_addr, cfg_data, sos_dout,
        input  in_ready, cfg_ready, sos_ce, sos_mult_sel, sos_c_we, sos_c_addr,
               sos_c_in, sos_din, out_valid, out_data, loaded, cfg_err
    );
endinterface

// File: rtl/iir_sos_seq.sv
// Sequencer for one second-order IIR section: accepts samples and coefficient
// writes, drives the section's ce / mult_sel / coefficient port / din from flops,
// and returns the section result with a one-cycle out_valid pulse.
// Ports:
//   c_clk : clock (posedge)
//   nrst  : asynchronous active-low reset
//   bus   : iir_sos_seq_if.slave (sample in, config in, section control, result out)
module iir_sos_seq #(
    parameter int unsigned SAMP_WH  = 3,
    parameter int unsigned SAMP_FR  = 22,
    parameter int unsigned COEFF_WH = 2,
    parameter int unsigned COEFF_FR = 15
) (
    input  logic           c_clk,
    input  logic           nrst,
    iir_sos_seq_if.slave   bus
);
    localparam int unsigned SAMP_W  = SAMP_WH + SAMP_FR;
    localparam int unsigned COEFF_W = COEFF_WH + COEFF_FR;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MAC0 = 3'd2,
        ST_MAC1 = 3'd3,
        ST_CAPT = 3'd4,
        ST_OUT  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               sos_ce_q, sos_ce_d;
    logic               sos_mult_sel_q, sos_mult_sel_d;
    logic               sos_c_we_q, sos_c_we_d;
    logic [1:0]         sos_c_addr_q, sos_c_addr_d;
    logic [COEFF_W-1:0] sos_c_in_q, sos_c_in_d;
    logic [SAMP_W-1:0]  sos_din_q, sos_din_d;
    logic               out_valid_q, out_valid_d;
    logic [SAMP_W-1:0]  out_data_q, out_data_d;
    logic [2:0]         loaded_q, loaded_d;
    logic               cfg_err_q, cfg_err_d;
    logic               in_ready_c;
    logic               cfg_ready_c;

    // State and output registers
    always_ff @(posedge c_clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= ST_IDLE;
            sos_ce_q       <= 1'b0;
            sos_mult_sel_q <= 1'b0;
            sos_c_we_q     <= 1'b0;
            sos_c_addr_q   <= 2'd0;
            sos_c_in_q     <= '0;
            sos_din_q      <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            loaded_q       <= 3'b000;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sos_ce_q       <= sos_ce_d;
            sos_mult_sel_q <= sos_mult_sel_d;
            sos_c_we_q     <= sos_c_we_d;
            sos_c_addr_q   <= sos_c_addr_d;
            sos_c_in_q     <= sos_c_in_d;
            sos_din_q      <= sos_din_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            loaded_q       <= loaded_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    // Next-state and next-output logic; each sos_* value is decided one state
    // early so the section sees it straight from a flop.
    always_comb begin
        state_d        = state_q;
        sos_ce_d       = 1'b0;
        sos_mult_sel_d = 1'b0;
        sos_c_we_d     = 1'b0;
        sos_c_addr_d   = sos_c_addr_q;
        sos_c_in_d     = sos_c_in_q;
        sos_din_d      = sos_din_q;
        out_valid_d    = 1'b0;
        out_data_d     = out_data_q;
        loaded_d       = loaded_q;
        cfg_err_d      = cfg_err_q;

        cfg_ready_c    = (state_q == ST_IDLE);
        // Config wins over samples, so a pending write hides in_ready.
        in_ready_c     = (state_q == ST_IDLE) && (loaded_q == 3'b111) && !bus.cfg_valid;

        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_valid) begin
                    state_d      = ST_LOAD;
                    sos_c_addr_d = bus.cfg_addr;
                    sos_c_in_d   = bus.cfg_data;
                    case (bus.cfg_addr)
                        2'd0:    begin sos_c_we_d = 1'b1; loaded_d[0] = 1'b1; end
                        2'd1:    begin sos_c_we_d = 1'b1; loaded_d[1] = 1'b1; end
                        2'd2:    begin sos_c_we_d = 1'b1; loaded_d[2] = 1'b1; end
                        default: cfg_err_d = 1'b1;
                    endcase
                end else if (bus.in_valid && in_ready_c) begin
                    state_d   = ST_MAC0;
                    sos_din_d = bus.in_data;
                    sos_ce_d  = 1'b1;
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            ST_MAC0: begin
                state_d        = ST_MAC1;
                sos_ce_d       = 1'b1;
                sos_mult_sel_d = 1'b1;
            end
            // ce falls entering CAPT; the section updates its output then.
            ST_MAC1: state_d = ST_CAPT;
            ST_CAPT: state_d = ST_OUT;
            ST_OUT: begin
                state_d     = ST_IDLE;
                out_data_d  = bus.sos_dout;
                out_valid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.cfg_ready    = cfg_ready_c;
    assign bus.sos_ce       = sos_ce_q;
    assign bus.sos_mult_sel = sos_mult_sel_q;
    assign bus.sos_c_we     = sos_c_we_q;
    assign bus.sos_c_addr   = sos_c_addr_q;
    assign bus.sos_c_in     = sos_c_in_q;
    assign bus.sos_din      = sos_din_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.loaded       = loaded_q;
    assign bus.cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_iir_sos_seq.sv
// Directed + randomized bench for iir_sos_seq with a small reference model of
// the loaded mask, sticky error and per-sample section result.
module tb_iir_sos_seq;
    localparam int unsigned SAMP_W  = 25;
    localparam int unsigned COEFF_W = 17;

    logic c_clk = 1'b0;
    logic nrst  = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [2:0]        m_loaded;
    logic              m_err;
    logic [SAMP_W-1:0] dout_next = '0;

    iir_sos_seq_if #(.SAMP_WH(3), .SAMP_FR(22), .COEFF_WH(2), .COEFF_FR(15)) bus ();

    iir_sos_seq #(.SAMP_WH(3), .SAMP_FR(22), .COEFF_WH(2), .COEFF_FR(15)) dut (
        .c_clk (c_clk),
        .nrst  (nrst),
        .bus   (bus)
    );

    always #5 c_clk = ~c_clk;

    // Section model: its output takes the prepared result when ce falls.
    always @(negedge bus.sos_ce) bus.sos_dout = dout_next;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        repeat (3) @(posedge c_clk);
        @(negedge c_clk);
        nrst = 1'b1;
        m_loaded = 3'b000;
        m_err    = 1'b0;
        tick();
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [COEFF_W-1:0] data);
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_data  = data;
        #1;
        chk("cfg_ready_idle", 32'(bus.cfg_ready), 32'd1);
        chk("in_ready_blocked_by_cfg", 32'(bus.in_ready), 32'd0);
        tick();
        bus.cfg_valid = 1'b0;
        if (addr == 2'd3) m_err = 1'b1;
        else m_loaded[addr] = 1'b1;
        chk("load_we", 32'(bus.sos_c_we), 32'(addr != 2'd3));
        chk("load_addr", 32'(bus.sos_c_addr), 32'(addr));
        chk("load_data", 32'(bus.sos_c_in), 32'(data));
        chk("load_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        chk("load_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("post_load_we", 32'(bus.sos_c_we), 32'd0);
        chk("loaded_mask", 32'(bus.loaded), 32'(m_loaded));
        chk("cfg_err", 32'(bus.cfg_err), 32'(m_err));
    endtask

    task automatic start_sample(input logic [SAMP_W-1:0] samp, input logic [SAMP_W-1:0] dout,
                                output int waited);
        bus.in_valid = 1'b1;
        bus.in_data  = samp;
        dout_next    = dout;
        waited       = 0;
        #1;
        while (!bus.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("in_ready_seen", 32'(bus.in_ready), 32'd1);
    endtask

    // From the accepting edge E0 to just after E4 (out_valid high).
    task automatic finish_sample(input logic [SAMP_W-1:0] samp, input logic [SAMP_W-1:0] dout);
        int ce_cycles;
        tick();
        bus.in_valid = 1'b0;
        ce_cycles = int'(bus.sos_ce);
        chk("mac0_sel", 32'(bus.sos_mult_sel), 32'd0);
        chk("mac0_din", 32'(bus.sos_din), 32'(samp));
        chk("mac0_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mac0_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        tick();
        ce_cycles += int'(bus.sos_ce);
        chk("mac1_sel", 32'(bus.sos_mult_sel), 32'd1);
        chk("mac1_din", 32'(bus.sos_din), 32'(samp));
        tick();
        ce_cycles += int'(bus.sos_ce);
        chk("capt_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        ce_cycles += int'(bus.sos_ce);
        chk("out_out_valid", 32'(bus.out_valid), 32'd0);
        chk("out_din", 32'(bus.sos_din), 32'(samp));
        chk("ce_high_cycles", 32'(ce_cycles), 32'd2);
        tick();
        chk("result_valid", 32'(bus.out_valid), 32'd1);
        chk("result_data", 32'(bus.out_data), 32'(dout));
        chk("result_ce", 32'(bus.sos_ce), 32'd0);
        chk("result_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    endtask

    initial begin
        int w;
        logic [SAMP_W-1:0]  s, d;
        logic [COEFF_W-1:0] cd;
        int st;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.cfg_valid = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_data  = '0;

        // Reset state
        do_reset();
        chk("rst_ce", 32'(bus.sos_ce), 32'd0);
        chk("rst_we", 32'(bus.sos_c_we), 32'd0);
        chk("rst_din", 32'(bus.sos_din), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_loaded", 32'(bus.loaded), 32'd0);
        chk("rst_cfg_err", 32'(bus.cfg_err), 32'd0);

        // Samples blocked until coefficients are loaded
        bus.in_valid = 1'b1;
        bus.in_data  = 25'h0400000;
        for (int i = 0; i < 6; i++) begin
            chk("noload_in_ready", 32'(bus.in_ready), 32'd0);
            chk("noload_ce", 32'(bus.sos_ce), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("noload_loaded", 32'(bus.loaded), 32'd0);

        // Fixed coefficient set
        cfg_write(2'd0, 17'h04000);
        cfg_write(2'd1, 17'h02000);
        cfg_write(2'd2, 17'h00100);

        // Fixed sample
        start_sample(25'h0400000, 25'h0123456, w);
        chk("first_wait", 32'(w), 32'd0);
        finish_sample(25'h0400000, 25'h0123456);
        tick();
        chk("pulse_one_cycle", 32'(bus.out_valid), 32'd0);
        chk("out_data_held", 32'(bus.out_data), 32'h0123456);

        // Config and sample offered together: config first
        bus.in_valid  = 1'b1;
        bus.in_data   = 25'h1abcdef;
        dout_next     = 25'h0777777;
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = 2'd1;
        bus.cfg_data  = 17'h1f000;
        #1;
        chk("prio_in_ready", 32'(bus.in_ready), 32'd0);
        chk("prio_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        tick();
        bus.cfg_valid = 1'b0;
        chk("prio_load_we", 32'(bus.sos_c_we), 32'd1);
        chk("prio_load_data", 32'(bus.sos_c_in), 32'h1f000);
        chk("prio_load_ce", 32'(bus.sos_ce), 32'd0);
        tick();
        chk("prio_idle_in_ready", 32'(bus.in_ready), 32'd1);
        finish_sample(25'h1abcdef, 25'h0777777);
        chk("prio_loaded_kept", 32'(bus.loaded), 32'h7);

        // Illegal address: no write, sticky error
        tick();
        cfg_write(2'd3, 17'h15555);
        start_sample(25'h0000001, 25'h1000000, w);
        finish_sample(25'h0000001, 25'h1000000);
        chk("err_sticky", 32'(bus.cfg_err), 32'd1);

        // Randomized: coefficient reload in random order, then back-to-back samples
        tick();
        st = $urandom_range(0, 2);
        for (int k = 0; k < 3; k++) begin
            cd = COEFF_W'($urandom);
            cfg_write(2'((st + k) % 3), cd);
        end
        for (int n = 0; n < 8; n++) begin
            s = SAMP_W'($urandom);
            d = SAMP_W'($urandom);
            start_sample(s, d, w);
            chk("b2b_wait", 32'(w), 32'd0);
            finish_sample(s, d);
        end
        tick();
        chk("b2b_end_valid", 32'(bus.out_valid), 32'd0);
        chk("err_still_set", 32'(bus.cfg_err), 32'd1);

        // Reset during MAC1
        start_sample(25'h0555555, 25'h0aaaaaa, w);
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("abort_pre_ce", 32'(bus.sos_ce), 32'd1);
        nrst = 1'b0;
        m_loaded = 3'b000;
        m_err    = 1'b0;
        #1;
        chk("abort_ce", 32'(bus.sos_ce), 32'd0);
        chk("abort_loaded", 32'(bus.loaded), 32'd0);
        chk("abort_err", 32'(bus.cfg_err), 32'd0);
        chk("abort_din", 32'(bus.sos_din), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_valid", 32'(bus.out_valid), 32'd0);
        end
        @(negedge c_clk);
        nrst = 1'b1;
        tick();
        chk("after_abort_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        chk("after_abort_in_ready", 32'(bus.in_ready), 32'd0);
        chk("after_abort_valid", 32'(bus.out_valid), 32'd0);

        // Recovery
        cfg_write(2'd2, 17'h00100);
        cfg_write(2'd0, 17'h04000);
        cfg_write(2'd1, 17'h02000);
        s = SAMP_W'($urandom);
        d = SAMP_W'($urandom);
        start_sample(s, d, w);
        finish_sample(s, d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
